// File: rtl/csr_seq_pkg.sv
// Shared types and helpers for the CSR access sequencer.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package csr_seq_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RSP   = 2'd3
  } csr_seq_state_t;

  // The RMW helper works on the widest supported CSR word; callers with a
  // narrower DATA_BITS extend the operands and truncate the result.
  localparam int CSR_MAX_DATA_BITS = 64;
  typedef logic [CSR_MAX_DATA_BITS-1:0] csr_word_t;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int csr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Value to write back for an op, given the old CSR value and the operand.
  function automatic csr_word_t csr_rmw(input csr_op_t op, input csr_word_t old,
                                        input csr_word_t data);
    csr_word_t res;
    case (op)
      CSR_OP_RW: res = data;
      CSR_OP_RS: res = old | data;
      CSR_OP_RC: res = old & ~data;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after rr_ptr.
// Latency: purely combinational.
// Backpressure: enable=0 forces a zero grant; the caller owns the pointer update.
module rr_arbiter
  import csr_seq_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int IDX_BITS = csr_idx_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDX_BITS-1:0] rr_ptr,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_BITS-1:0] grant_idx
);

  // Scan requesters starting at rr_ptr, wrapping, and pick the first valid one.
  always_comb begin
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (enable) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        j = int'(rr_ptr) + i;
        if (j >= NUM_REQS) j = j - NUM_REQS;
        if (!found && valid[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_BITS'(j);
        end
      end
    end
  end

endmodule

// File: rtl/csr_access_seq.sv
// CSR access sequencer: round-robin arbitration, atomic read-modify-write, old value returned.
// Latency: accept to rsp_valid 2 cycles (no write) or 3 (write); one op in flight.
// Backpressure: rsp held stable until rsp_ready; no new grant until the response fires.
// Build option CSR_SEQ_OVERLAP_EN: arbitrate during the response-fire cycle, skipping IDLE.
module csr_access_seq
  import csr_seq_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int ADDR_BITS = 12,
  parameter int WID_BITS  = 2,
  parameter int UUID_BITS = 44,
  parameter int DATA_BITS = 32,
  localparam int IDX_BITS = csr_idx_w(NUM_REQS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  output logic [NUM_REQS-1:0]           req_ready,
  input  logic [NUM_REQS*2-1:0]         req_op,
  input  logic [NUM_REQS*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQS*WID_BITS-1:0]  req_wid,
  input  logic [NUM_REQS*UUID_BITS-1:0] req_uuid,
  input  logic [NUM_REQS*DATA_BITS-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDX_BITS-1:0]           rsp_idx,
  output logic [UUID_BITS-1:0]          rsp_uuid,
  output logic [DATA_BITS-1:0]          rsp_data,
  output logic                          read_enable,
  output logic [ADDR_BITS-1:0]          read_addr,
  output logic [WID_BITS-1:0]           read_wid,
  output logic [UUID_BITS-1:0]          read_uuid,
  input  logic [DATA_BITS-1:0]          read_data,
  output logic                          write_enable,
  output logic [ADDR_BITS-1:0]          write_addr,
  output logic [WID_BITS-1:0]           write_wid,
  output logic [UUID_BITS-1:0]          write_uuid,
  output logic [DATA_BITS-1:0]          write_data,
  output logic                          busy
);

  csr_seq_state_t        state, state_nxt;
  logic [IDX_BITS-1:0]   rr_ptr;
  logic [IDX_BITS-1:0]   grant_idx;
  logic [NUM_REQS-1:0]   grant;
  logic                  arb_en;
  logic                  grant_any;
  logic                  need_write;

  csr_op_t               cap_op;
  logic [ADDR_BITS-1:0]  cap_addr;
  logic [WID_BITS-1:0]   cap_wid;
  logic [UUID_BITS-1:0]  cap_uuid;
  logic [DATA_BITS-1:0]  cap_data;
  logic [IDX_BITS-1:0]   cap_idx;
  logic [DATA_BITS-1:0]  cap_old;

  // Arbitration is held off during reset so req_ready reads zero there too.
`ifdef CSR_SEQ_OVERLAP_EN
  assign arb_en = !reset && ((state == ST_IDLE) || (state == ST_RSP && rsp_ready));
`else
  assign arb_en = !reset && (state == ST_IDLE);
`endif

  rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .IDX_BITS (IDX_BITS)
  ) u_arb (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;

  // A zero RS/RC mask leaves the CSR untouched, so the write cycle is skipped.
  assign need_write = (cap_op == CSR_OP_RW) ||
                      (((cap_op == CSR_OP_RS) || (cap_op == CSR_OP_RC)) && (cap_data != '0));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_any) state_nxt = ST_READ;
      ST_READ:  state_nxt = need_write ? ST_WRITE : ST_RSP;
      ST_WRITE: state_nxt = ST_RSP;
      ST_RSP: begin
`ifdef CSR_SEQ_OVERLAP_EN
        if (rsp_ready) state_nxt = grant_any ? ST_READ : ST_IDLE;
`else
        if (rsp_ready) state_nxt = ST_IDLE;
`endif
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture the granted request, advance the pointer, latch the old CSR value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      cap_op   <= CSR_OP_READ;
      cap_addr <= '0;
      cap_wid  <= '0;
      cap_uuid <= '0;
      cap_data <= '0;
      cap_idx  <= '0;
      cap_old  <= '0;
    end else begin
      if (grant_any) begin
        cap_op   <= csr_op_t'(req_op[int'(grant_idx)*2 +: 2]);
        cap_addr <= req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
        cap_wid  <= req_wid[int'(grant_idx)*WID_BITS +: WID_BITS];
        cap_uuid <= req_uuid[int'(grant_idx)*UUID_BITS +: UUID_BITS];
        cap_data <= req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
        cap_idx  <= grant_idx;
        if (int'(grant_idx) == NUM_REQS-1) rr_ptr <= '0;
        else                               rr_ptr <= grant_idx + 1'b1;
      end
      if (state == ST_READ) cap_old <= read_data;
    end
  end

  // Strobes and handshakes decoded from state; address fields come from the capture.
  always_comb begin
    req_ready    = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      req_ready    = grant;
      read_enable  = (state == ST_READ);
      write_enable = (state == ST_WRITE);
      rsp_valid    = (state == ST_RSP);
      busy         = (state != ST_IDLE);
    end
    read_addr  = cap_addr;
    read_wid   = cap_wid;
    read_uuid  = cap_uuid;
    write_addr = cap_addr;
    write_wid  = cap_wid;
    write_uuid = cap_uuid;
    write_data = DATA_BITS'(csr_rmw(cap_op, csr_word_t'(cap_old), csr_word_t'(cap_data)));
    rsp_idx    = cap_idx;
    rsp_uuid   = cap_uuid;
    rsp_data   = cap_old;
  end

endmodule

// File: doc/csr_access_seq.md
Name: csr_access_seq

Overview:
- Sequences shared access to the per-core CSR data file.
- The file has a single read port and a single write port.
- NUM_REQS requesters (CSR issue slot, debug/DCR path, …) submit CSR ops: READ, RW, RS, RC.
- Block arbitrates round-robin, performs an atomic read-modify-write on the data file, and returns the old value on a valid/ready response channel.
- Sits between issue/CSR-unit requesters and the CSR data file.

Parameters:
- NUM_REQS, 2, number of requesters (≥1).
- ADDR_BITS, 12, CSR address width.
- WID_BITS, 2, warp id width.
- UUID_BITS, 44, instruction uuid width.
- DATA_BITS, 32, CSR data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  per-requester request valid
- req_ready  out  NUM_REQS  one-hot grant/accept
- req_op  in  NUM_REQS*2  per-requester op: 0=READ, 1=RW, 2=RS, 3=RC
- req_addr  in  NUM_REQS*ADDR_BITS  CSR address
- req_wid  in  NUM_REQS*WID_BITS  warp id
- req_uuid  in  NUM_REQS*UUID_BITS  uuid
- req_data  in  NUM_REQS*DATA_BITS  write operand/mask
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_idx  out  clog2(NUM_REQS) (min 1)  originating requester
- rsp_uuid  out  UUID_BITS  uuid of the completed op
- rsp_data  out  DATA_BITS  CSR value before the op
- read_enable  out  1  CSR file read strobe
- read_addr  out  ADDR_BITS  CSR file read address
- read_wid  out  WID_BITS  CSR file read warp id
- read_uuid  out  UUID_BITS  CSR file read uuid
- read_data  in  DATA_BITS  combinational CSR file read data
- write_enable  out  1  CSR file write strobe
- write_addr  out  ADDR_BITS  CSR file write address
- write_wid  out  WID_BITS  CSR file write warp id
- write_uuid  out  UUID_BITS  CSR file write uuid
- write_data  out  DATA_BITS  CSR file write data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, READ, WRITE, RSP.
- Reset:
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, read_enable, write_enable, busy.
  - Captured request/data registers are cleared.
  - A reset mid-operation abandons the op. No write is issued after reset, even if it was pending.
- IDLE:
  - req_ready = one-hot grant to the first valid requester at or after rr_ptr (wrapping). Zero if none valid.
  - On grant, capture op/addr/wid/uuid/data/idx, set rr_ptr = grant_idx+1 mod NUM_REQS, go to READ.
  - req_ready is only ever nonzero in IDLE (or see optional feature).
- READ (1 cycle):
  - read_enable=1; read_addr/wid/uuid come from the captured registers.
  - Capture old = read_data.
  - Next state is WRITE when any of: op==RW; op==RS with data!=0; op==RC with data!=0.
  - Otherwise (READ, or RS/RC with zero mask) next state is RSP.
- WRITE (1 cycle):
  - write_enable=1; write_addr/wid/uuid come from the captured registers.
  - write_data: RW=data; RS=old|data; RC=old&~data. All values are DATA_BITS wide.
  - Next state is RSP.
- RSP:
  - rsp_valid=1; rsp_data=old, rsp_idx, rsp_uuid.
  - Held stable until rsp_ready. On fire, go to IDLE.
- Timing:
  - Accept-to-rsp_valid latency: 2 cycles (no write) or 3 cycles (write).
  - Minimum issue interval: 4 cycles (3 without write).
- Ordering and atomicity:
  - Responses are strictly in grant order; a single op is in flight.
  - The read and write of one op are never interleaved with another requester, so RMW is atomic.
- Fairness:
  - Requester i, after being granted, has the lowest priority at the next grant.
  - A requester that keeps req_valid high is granted within NUM_REQS grants.
- Boundary cases:
  - NUM_REQS=1: rr_ptr constant 0.
  - req_valid dropping before grant is legal.
  - Inputs are ignored outside IDLE.

Optional Feature:
- Macro: CSR_SEQ_OVERLAP_EN.
- Defined:
  - In RSP, on the cycle rsp_valid&&rsp_ready, arbitration runs as in IDLE.
  - If a request is granted that cycle, go directly to READ (no IDLE bubble).
  - Issue interval drops to 3 (2 without write).
  - busy stays 1 through the overlap.
- Undefined: the FSM as above; req_ready=0 in RSP.

Decomposition:
- Shared package csr_seq_pkg holds:
  - Op enum csr_op_t: READ, RW, RS, RC (2 bits).
  - State enum csr_seq_state_t.
  - Function csr_rmw(op, old, data) returning the write value.
- Sub-module rr_arbiter (NUM_REQS): inputs valid, rr_ptr, enable; outputs one-hot grant and index.
- Hierarchy: csr_access_seq instantiates rr_arbiter once.

Test Plan:
- Single READ of addr 0xF14 on req0, read_data=0x0000_0005:
  - No write_enable.
  - rsp_valid 2 cycles after accept; rsp_data=5, rsp_idx=0.
- RS on addr 0x300, old=0x0000_0008, data=0x0000_0080:
  - Exactly one write_enable with write_data=0x88.
  - rsp_data=0x8.
- RC with data=0, and RS with data=0:
  - No write_enable in either case; rsp_data=old.
- RC with old=0xFF, data=0x0F: write_data=0xF0.
- Both requesters hold req_valid for 4 ops:
  - Grants alternate 0,1,0,1.
  - rsp_idx matches the grant order.
  - No read/write overlap between ops.
- Backpressure:
  - rsp_ready=0 for 5 cycles: rsp_valid/data held stable, no new req_ready, busy=1.
  - Assert reset in WRITE state: next cycle write_enable=0, rsp_valid=0, busy=0, rr_ptr=0.
